// File: rtl/lis3dh_cfg_seq.sv
// LIS3DH configuration sequencer: issues the fixed register-write frames to an spi_master.
// Optional build macro LIS3DH_CFG_SEQ_READBACK_EN appends a WHO_AM_I read frame (0x8F00).
module lis3dh_cfg_seq #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACC_TIMEOUT = 15
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start,
  input  logic        ready,
  output logic        request,
  output logic [4:0]  nbits,
  output logic [31:0] mosi_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  frame_idx
);

  // state     | meaning
  // IDLE      | waiting for start with the master idle
  // REQ       | one-cycle frame request, frame word already on mosi_data
  // WAIT_ACC  | waiting for the master to drop ready (accept timeout armed)
  // WAIT_DONE | frame on the wire, waiting for ready to return
  // GAP       | chip-select high time between frames
  // DONE      | one-cycle completion pulse
  // ERROR     | master never accepted the frame
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_ACC  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4,
    S_DONE      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

`ifdef LIS3DH_CFG_SEQ_READBACK_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] ACC_LOAD    = 8'(ACC_TIMEOUT - 1);
  localparam logic [4:0] NBITS_FRAME = 5'd15;

  function automatic logic [15:0] frame_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h2057;
      3'd1:    w = 16'h2180;
      3'd2:    w = 16'h2388;
      3'd3:    w = 16'h1FC0;
`ifdef LIS3DH_CFG_SEQ_READBACK_EN
      3'd4:    w = 16'h8F00;
`endif
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  tmr_q;
  logic [2:0]  idx_q;
  logic [15:0] data_q;
  logic [4:0]  nbits_q;
  logic        error_q;

  logic start_ok;
  logic tmr_zero;
  logic last_frame;

  assign start_ok   = start && ready;
  assign tmr_zero   = (tmr_q == 8'd0);
  assign last_frame = (idx_q == LAST_IDX);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_REQ;
      end
      S_REQ: begin
        // never present a request to a master that is mid-frame
        if (ready) state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        if (!ready)        state_d = S_WAIT_DONE;
        else if (tmr_zero) state_d = S_ERROR;
      end
      S_WAIT_DONE: begin
        if (ready) state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_zero) state_d = last_frame ? S_DONE : S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // shared down-counter: accept timeout in WAIT_ACC, chip-select gap in GAP
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tmr_q <= 8'd0;
    end else if (state_d == S_WAIT_ACC && state_q != S_WAIT_ACC) begin
      tmr_q <= ACC_LOAD;
    end else if (state_d == S_GAP && state_q != S_GAP) begin
      tmr_q <= GAP_LOAD;
    end else if ((state_q == S_WAIT_ACC || state_q == S_GAP) && !tmr_zero) begin
      tmr_q <= tmr_q - 8'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      idx_q   <= 3'd0;
      data_q  <= 16'h0000;
      nbits_q <= 5'd0;
      error_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start_ok) begin
        idx_q   <= 3'd0;
        data_q  <= frame_word(3'd0);
        nbits_q <= NBITS_FRAME;
        error_q <= 1'b0;
      end else if (state_q == S_GAP && tmr_zero && !last_frame) begin
        idx_q  <= idx_q + 3'd1;
        data_q <= frame_word(idx_q + 3'd1);
      end
      if (state_d == S_ERROR) error_q <= 1'b1;
    end
  end

  always_comb begin
    request   = (state_q == S_REQ) && ready;
    busy      = (state_q == S_REQ) || (state_q == S_WAIT_ACC) ||
                (state_q == S_WAIT_DONE) || (state_q == S_GAP);
    done      = (state_q == S_DONE);
    error     = error_q;
    nbits     = nbits_q;
    mosi_data = {16'h0000, data_q};
    frame_idx = idx_q;
  end

endmodule

// File: doc/lis3dh_cfg_seq.md
LIS3DH_CFG_SEQ -- requirements
Module: lis3dh_cfg_seq

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle clk_in cycles between frames (chip-select high time), legal range 1..255.
REQ-002 Parameter ACC_TIMEOUT, default 15: maximum cycles after request for ready to fall before error, legal range 1..255.
REQ-003 clk_in  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin the configuration sequence; sampled in IDLE only.
REQ-006 ready  input  1  from spi_master; high = master idle, low = frame in progress.
REQ-007 request  output  1  one-cycle frame request to spi_master.
REQ-008 nbits  output  5  frame length minus one; driven to 15 for every frame.
REQ-009 mosi_data  output  32  frame word to spi_master; bits 31:16 zero.
REQ-010 busy  output  1  high from leaving IDLE until DONE or ERROR is entered.
REQ-011 done  output  1  one-cycle pulse on successful sequence completion.
REQ-012 error  output  1  sticky accept-timeout flag.
REQ-013 frame_idx  output  3  index of the current or last frame issued.

Function
REQ-014 Frame table SHALL be fixed, in order: 0x2057 (CTRL_REG1), 0x2180 (CTRL_REG2), 0x2388 (CTRL_REG4), 0x1FC0 (TEMP_CFG_REG).
REQ-015 States SHALL be IDLE, REQ, WAIT_ACC, WAIT_DONE, GAP, DONE, ERROR.
REQ-016 IDLE: start=1 and ready=1 -> REQ with frame_idx=0, error cleared; start=1 with ready=0 -> stay in IDLE, start dropped.
REQ-017 REQ: request=1 for exactly one cycle, with mosi_data/nbits already valid; next state WAIT_ACC.
REQ-018 mosi_data and nbits SHALL stay stable from REQ until WAIT_DONE exits.
REQ-019 WAIT_ACC: ready=0 -> WAIT_DONE; after ACC_TIMEOUT cycles with ready=1 -> ERROR.
REQ-020 WAIT_DONE: ready=1 -> GAP; no timeout in this state.
REQ-021 GAP: hold GAP_CYCLES cycles; then REQ with frame_idx+1 if frames remain, else DONE.
REQ-022 DONE: done=1 for one cycle, busy=0; next IDLE.
REQ-023 ERROR: error=1, request=0, busy=0; next IDLE; error holds until the next accepted start.
REQ-024 start while busy SHALL be ignored (no restart, no queueing).
REQ-025 First request SHALL occur 1 cycle after start is sampled; consecutive requests SHALL be separated by at least GAP_CYCLES+2 cycles.
REQ-026 request SHALL never assert while ready=0.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, request=0, nbits=0, mosi_data=0, busy=0, done=0, error=0, frame_idx=0, counters=0.
REQ-028 Reset mid-sequence SHALL abandon the sequence with no further request; the first cycle after deassert is IDLE.

Configuration
REQ-029 Macro LIS3DH_CFG_SEQ_READBACK_EN defined: a fifth frame 0x8F00 (WHO_AM_I read) follows the table, frame_idx reaches 4, and done fires after it.
REQ-030 Macro LIS3DH_CFG_SEQ_READBACK_EN undefined: exactly four write frames, no read frame logic synthesized, frame_idx maximum 3.

Verification
REQ-031 Reset release, start pulse, ready-following master model -> requests carry 0x2057, 0x2180, 0x2388, 0x1FC0 in order, nbits=15, then one done pulse.
REQ-032 Master model holding ready=1 after the first request -> error=1 after 15 cycles, busy=0, no second request; a later start clears error.
REQ-033 start asserted while busy during frame 2 -> sequence unchanged, exactly 4 requests, 1 done.
REQ-034 reset asserted during WAIT_DONE of frame 1 -> all outputs zero immediately, no request until a new start.
REQ-035 GAP_CYCLES=4 -> at least 6 cycles measured between consecutive request pulses; mosi_data stable while ready=0.
REQ-036 With LIS3DH_CFG_SEQ_READBACK_EN -> fifth request carries 0x8F00 with frame_idx=4; lis3dh_stub returns 0x33 on spi_sdo.
